// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and the dump FSM state type for the
// register file slice.
//   NREGS    - architectural register count (X0..X31)
//   XZR_IDX  - index of the hard-wired zero register
//   ADDR_W   - register address width
//   dump_state_e - dump streamer states
package regfile_pkg;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_e;

endpackage

// File: rtl/regfile_decoder5to32.sv
// decoder5to32: write-enable decoder for the register file.
//   wa3 [4:0]  - write address
//   we3        - write enable
//   en  [31:0] - one-hot per-register write enable; bit 31 (XZR) never set
module decoder5to32
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0] wa3,
  input  logic              we3,
  output logic [NREGS-1:0]  en
);

  always_comb begin
    en = '0;
    if (we3 && (wa3 != XZR_IDX))
      en[wa3] = 1'b1;
  end

endmodule

// File: rtl/regfile.sv
// regfile: 31 x N-bit register file (X0..X30) plus zero register X31, with
// two combinational read ports, one write port and a dump streamer that
// walks all 32 indices over a valid/ready interface.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   we3, wa3, wd3     - write port
//   ra1/rd1, ra2/rd2  - combinational read ports
//   dump_start        - pulse in IDLE to begin a dump
//   dump_valid/ready  - dump element handshake
//   dump_idx/data     - current dump element
//   dump_busy         - dump FSM is in SEND
//
// Build option: define REGFILE_BYPASS_EN to make reads write-through
// (same-cycle write data forwarded to a matching read port).
module regfile
  import regfile_pkg::*;
#(
  parameter int N = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [N-1:0]      wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [N-1:0]      rd1,
  output logic [N-1:0]      rd2,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [N-1:0]      dump_data,
  output logic              dump_busy
);

  // Entry 31 exists only to keep indexing uniform; it is held at zero and
  // never enabled by the decoder.
  logic [N-1:0] regs [NREGS];
  logic [NREGS-1:0] wen;

  dump_state_e       state, state_n;
  logic [ADDR_W-1:0] idx_n;
  logic [N-1:0]      data_n;

  decoder5to32 u_dec (
    .wa3 (wa3),
    .we3 (we3),
    .en  (wen)
  );

  // Register array
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS - 1; i++)
        regs[i] <= N'(i);
      regs[NREGS-1] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (wen[i]) regs[i] <= wd3;
    end
  end

  // Read ports
  always_comb begin
    rd1 = (ra1 == XZR_IDX) ? '0 : regs[ra1];
    rd2 = (ra2 == XZR_IDX) ? '0 : regs[ra2];
`ifdef REGFILE_BYPASS_EN
    if (we3 && (wa3 == ra1) && (ra1 != XZR_IDX)) rd1 = wd3;
    if (we3 && (wa3 == ra2) && (ra2 != XZR_IDX)) rd2 = wd3;
`endif
  end

  // Dump FSM state and element registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dump_idx  <= '0;
      dump_data <= '0;
    end else begin
      state     <= state_n;
      dump_idx  <= idx_n;
      dump_data <= data_n;
    end
  end

  // Captures read regs[] before this edge's write lands, so a simultaneous
  // write to the captured register yields the pre-write value.
  always_comb begin
    state_n = state;
    idx_n   = dump_idx;
    data_n  = dump_data;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_n = SEND;
          idx_n   = '0;
          data_n  = regs[0];
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (dump_idx == XZR_IDX) begin
            state_n = IDLE;
            idx_n   = '0;
            data_n  = '0;
          end else begin
            idx_n  = dump_idx + 5'd1;
            data_n = (idx_n == XZR_IDX) ? '0 : regs[idx_n];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign dump_valid = (state == SEND);
  assign dump_busy  = (state == SEND);

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         we3;
  logic [4:0]   wa3;
  logic [N-1:0] wd3;
  logic [4:0]   ra1, ra2;
  logic [N-1:0] rd1, rd2;
  logic         dump_start, dump_valid, dump_ready, dump_busy;
  logic [4:0]   dump_idx;
  logic [N-1:0] dump_data;

  int n_cmp = 0;
  int n_err = 0;

  regfile #(.N(N)) dut (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy)
  );

  always #5 clk = ~clk;

  // Inputs change on negedge; checks happen on negedge (+#1 for comb reads).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; we3 = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0 || dump_data !== '0) begin
      n_err++;
      $display("FAIL reset_dump: valid=%b busy=%b idx=%0d data=%h, required 0/0/0/0",
               dump_valid, dump_busy, dump_idx, dump_data);
    end
    ra1 = 5'd5; ra2 = 5'd30; #1;
    n_cmp++;
    if (rd1 !== 64'd5) begin n_err++; $display("FAIL reset_rd1: got %h required %h", rd1, 64'd5); end
    n_cmp++;
    if (rd2 !== 64'd30) begin n_err++; $display("FAIL reset_rd2: got %h required %h", rd2, 64'd30); end
    ra1 = 5'd31; ra2 = 5'd0; #1;
    n_cmp++;
    if (rd1 !== 64'd0) begin n_err++; $display("FAIL reset_xzr: got %h required 0", rd1); end
    n_cmp++;
    if (rd2 !== 64'd0) begin n_err++; $display("FAIL reset_x0: got %h required 0", rd2); end
  endtask

  task automatic test_write_read();
    logic [N-1:0] exp_same;
    do_reset();
`ifdef REGFILE_BYPASS_EN
    exp_same = 64'hDEADBEEF;
`else
    exp_same = 64'd7;
`endif
    we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hDEADBEEF; ra1 = 5'd7; ra2 = 5'd8; #1;
    n_cmp++;
    if (rd1 !== exp_same) begin n_err++; $display("FAIL wr_same_cycle: got %h required %h", rd1, exp_same); end
    n_cmp++;
    if (rd2 !== 64'd8) begin n_err++; $display("FAIL wr_other_port: got %h required %h", rd2, 64'd8); end
    @(negedge clk);
    we3 = 1'b0; #1;
    n_cmp++;
    if (rd1 !== 64'hDEADBEEF) begin n_err++; $display("FAIL wr_next_cycle: got %h required %h", rd1, 64'hDEADBEEF); end
    // highest writable register
    we3 = 1'b1; wa3 = 5'd30; wd3 = 64'hFFFF_0000_1234_5678; ra2 = 5'd30;
    @(negedge clk);
    we3 = 1'b0; #1;
    n_cmp++;
    if (rd2 !== 64'hFFFF_0000_1234_5678) begin n_err++; $display("FAIL wr_x30: got %h required %h", rd2, 64'hFFFF_0000_1234_5678); end
  endtask

  task automatic test_xzr();
    do_reset();
    we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hFFFF; ra1 = 5'd31; ra2 = 5'd31; #1;
    n_cmp++;
    if (rd1 !== 64'd0) begin n_err++; $display("FAIL xzr_same_cycle: got %h required 0", rd1); end
    @(negedge clk);
    we3 = 1'b0; #1;
    n_cmp++;
    if (rd1 !== 64'd0) begin n_err++; $display("FAIL xzr_after: got %h required 0", rd1); end
  endtask

  task automatic test_dump_full();
    logic [N-1:0] exp_d;
    do_reset();
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0; dump_ready = 1'b1;
    for (int b = 0; b < 32; b++) begin
      exp_d = (b < 31) ? N'(b) : '0;
      n_cmp++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_idx !== 5'(b) || dump_data !== exp_d) begin
        n_err++;
        $display("FAIL dump_beat%0d: valid=%b busy=%b idx=%0d data=%h, required 1/1/%0d/%h",
                 b, dump_valid, dump_busy, dump_idx, dump_data, b, exp_d);
      end
      dump_start = (b == 3);  // ignored while sending
      @(negedge clk);
    end
    dump_start = 1'b0;
    n_cmp++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
      n_err++;
      $display("FAIL dump_end: valid=%b busy=%b, required 0/0", dump_valid, dump_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (dump_valid !== 1'b0) begin n_err++; $display("FAIL dump_stays_idle: valid=%b required 0", dump_valid); end
    dump_ready = 1'b0;
  endtask

  task automatic test_dump_stall();
    do_reset();
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0; dump_ready = 1'b1;
    for (int b = 0; b < 4; b++) @(negedge clk);
    n_cmp++;
    if (dump_idx !== 5'd4 || dump_data !== 64'd4) begin
      n_err++; $display("FAIL stall_reach4: idx=%0d data=%h, required 4/4", dump_idx, dump_data);
    end
    dump_ready = 1'b0; we3 = 1'b1; wa3 = 5'd4; wd3 = 64'h55;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      we3 = 1'b0;
      n_cmp++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'd4 || dump_data !== 64'd4) begin
        n_err++;
        $display("FAIL stall_hold%0d: valid=%b idx=%0d data=%h, required 1/4/4", c, dump_valid, dump_idx, dump_data);
      end
    end
    dump_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dump_idx !== 5'd5 || dump_data !== 64'd5) begin
      n_err++; $display("FAIL stall_resume: idx=%0d data=%h, required 5/5", dump_idx, dump_data);
    end
    // capture of X6 and write of X6 on the same edge -> pre-write value
    we3 = 1'b1; wa3 = 5'd6; wd3 = 64'hAA; dump_ready = 1'b1;
    @(negedge clk);
    we3 = 1'b0; dump_ready = 1'b0; ra1 = 5'd6; ra2 = 5'd4; #1;
    n_cmp++;
    if (dump_idx !== 5'd6 || dump_data !== 64'd6) begin
      n_err++; $display("FAIL capture_prewrite: idx=%0d data=%h, required 6/6", dump_idx, dump_data);
    end
    n_cmp++;
    if (rd1 !== 64'hAA) begin n_err++; $display("FAIL x6_written: got %h required aa", rd1); end
    n_cmp++;
    if (rd2 !== 64'h55) begin n_err++; $display("FAIL x4_written: got %h required 55", rd2); end
  endtask

  task automatic test_dump_abort();
    do_reset();
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0; dump_ready = 1'b1;
    for (int b = 0; b < 10; b++) @(negedge clk);
    n_cmp++;
    if (dump_idx !== 5'd10) begin n_err++; $display("FAIL abort_reach10: idx=%0d required 10", dump_idx); end
    // reset beats a same-cycle write and start
    reset = 1'b1; we3 = 1'b1; wa3 = 5'd2; wd3 = 64'h99; dump_start = 1'b1;
    @(negedge clk);
    reset = 1'b0; we3 = 1'b0; dump_start = 1'b0; ra1 = 5'd2; #1;
    n_cmp++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0 || dump_data !== '0) begin
      n_err++;
      $display("FAIL abort_state: valid=%b busy=%b idx=%0d data=%h, required 0/0/0/0",
               dump_valid, dump_busy, dump_idx, dump_data);
    end
    n_cmp++;
    if (rd1 !== 64'd2) begin n_err++; $display("FAIL reset_over_write: got %h required 2", rd1); end
    dump_start = 1'b1; dump_ready = 1'b0;
    @(negedge clk);
    dump_start = 1'b0;
    n_cmp++;
    if (dump_valid !== 1'b1 || dump_idx !== 5'd0 || dump_data !== 64'd0) begin
      n_err++; $display("FAIL restart: valid=%b idx=%0d data=%h, required 1/0/0", dump_valid, dump_idx, dump_data);
    end
    dump_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dump_idx !== 5'd1 || dump_data !== 64'd1) begin
      n_err++; $display("FAIL restart_next: idx=%0d data=%h, required 1/1", dump_idx, dump_data);
    end
  endtask

  initial begin
    reset = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    test_reset();
    test_write_read();
    test_xzr();
    test_dump_full();
    test_dump_stall();
    test_dump_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL provide parameter N, default 64, data width of each register and of all data ports.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port we3, input, 1, write enable for the write port.
REQ-005 SHALL have port wa3, input, 5, write address.
REQ-006 SHALL have port wd3, input, N, write data.
REQ-007 SHALL have ports ra1 and ra2, input, 5 each, read addresses.
REQ-008 SHALL have ports rd1 and rd2, output, N each, combinational read data.
REQ-009 SHALL have port dump_start, input, 1, single-cycle request to stream out all registers.
REQ-010 SHALL have port dump_valid, output, 1, dump element is valid.
REQ-011 SHALL have port dump_ready, input, 1, consumer accepts the dump element.
REQ-012 SHALL have port dump_idx, output, 5, register index of the current dump element.
REQ-013 SHALL have port dump_data, output, N, value of the current dump element.
REQ-014 SHALL have port dump_busy, output, 1, high while the dump FSM is not IDLE.

Function
REQ-015 SHALL hold 31 writable N-bit registers X0..X30; X31 (XZR) SHALL always read 0.
REQ-016 SHALL write wd3 into X[wa3] on the rising clk edge when we3=1 and wa3!=31; a write to 31 is discarded.
REQ-017 SHALL drive rd1=X[ra1] and rd2=X[ra2] combinationally, zero latency.
REQ-018 SHALL implement the dump FSM with states IDLE and SEND only.
REQ-019 In IDLE, dump_start=1 SHALL move to SEND next cycle with dump_idx=0, dump_data=X0 captured at that edge, dump_valid=1.
REQ-020 In SEND, dump_valid=1; dump_idx and dump_data SHALL stay stable until dump_valid&&dump_ready.
REQ-021 On handshake with dump_idx<31, SHALL increment dump_idx and capture the next register into dump_data the same edge.
REQ-022 On handshake with dump_idx=31 (dump_data=0), SHALL return to IDLE; dump_valid=0 the following cycle.
REQ-023 dump_start while in SEND SHALL be ignored; no restart, no queueing.
REQ-024 A write to the register currently held in dump_data SHALL not change dump_data; the updated value is seen only if captured later.
REQ-025 Simultaneous write and dump capture of the same register SHALL capture the pre-write value.
REQ-026 dump_busy SHALL equal (state==SEND).

Reset
REQ-027 reset=1 at a rising edge SHALL load X[i]=i for i=0..30, with N-bit zero extension.
REQ-028 reset SHALL force IDLE, dump_valid=0, dump_idx=0, dump_data=0, dump_busy=0, aborting any dump in progress.
REQ-029 reset SHALL take priority over we3 and dump_start in the same cycle.

Configuration
REQ-030 With macro REGFILE_BYPASS_EN defined, rd1/rd2 SHALL return wd3 when we3=1, wa3==ra, ra!=31 (write-through).
REQ-031 Without REGFILE_BYPASS_EN, rd1/rd2 SHALL return the pre-write stored value during a same-cycle write.

Structure
REQ-032 Package regfile_pkg SHALL hold NREGS=32, XZR_IDX=31, ADDR_W=5 and the dump state enum typedef.
REQ-033 Write-enable generation SHALL be a sub-module decoder5to32 (wa3, we3 -> 32-bit one-hot enable, bit 31 forced 0).

Verification
REQ-034 Reset, then ra1=5, ra2=30 -> rd1=5, rd2=30.
REQ-035 we3=1, wa3=7, wd3=0xDEADBEEF, ra1=7 same cycle -> rd1=7 without the macro, 0xDEADBEEF with it; next cycle rd1=0xDEADBEEF.
REQ-036 we3=1, wa3=31, wd3=0xFFFF -> after the edge, ra1=31 gives rd1=0.
REQ-037 dump_start pulse, dump_ready=1 always -> 32 beats, idx 0..31, data 0..30 then 0; dump_busy falls after beat 31.
REQ-038 dump_ready low 3 cycles at idx 4, write X4=0x55 meanwhile -> idx/data hold 4/4 until ready; idx 5 follows.
REQ-039 reset asserted at idx 10 -> next cycle dump_valid=0, dump_busy=0, idx=0; a new dump_start restarts at idx 0.
